wr_cmd_buffer: RTL and testbench
================================

# wr_cmd_buffer

Write-command buffer between the test pattern writer and the SDRAM controller write port. Captures every single-cycle write strobe (address + data) from the pattern writer into a small FIFO, presents commands to the controller with a valid/ready handshake, and reports occupancy, accepted-command count and a sticky overflow flag. The controller can stall without losing strobes unless the buffer overflows.

## Interface
Parameters:
- AW, 25, address width (matches controller word address)
- DW, 32, data width
- DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- w  in  1  write strobe from pattern writer, one cycle per command
- adr  in  AW  write address, valid when w=1
- d  in  DW  write data, valid when w=1
- cmd_valid  out  1  command at FIFO head available
- cmd_adr  out  AW  head address
- cmd_d  out  DW  head data
- cmd_ready  in  1  controller accepts head this cycle
- full  out  1  FIFO holds 2^DEPTH_LOG2 entries
- empty  out  1  FIFO holds 0 entries
- level  out  DEPTH_LOG2+1  current occupancy
- ovf  out  1  sticky: a strobe was dropped
- clr_ovf  in  1  synchronous clear of ovf
- wr_count  out  32  number of accepted commands, saturating

## Operation
- Push: w=1 and (not full, or pop in same cycle) -> entry {adr,d} written at wr_ptr, wr_ptr+1.
- Pop: cmd_valid=1 and cmd_ready=1 -> rd_ptr+1. cmd_ready ignored when cmd_valid=0.
- Drop: w=1, full=1, no pop this cycle -> strobe discarded, ovf set next cycle, wr_count unchanged.
- Push and pop same cycle: level unchanged; allowed both when full (pop frees slot) and at any intermediate level. When empty, no pop is possible (cmd_valid=0), so push alone.
- Pointers DEPTH_LOG2+1 bits, wrap modulo 2^(DEPTH_LOG2+1); full = MSBs differ and LSBs equal; empty = pointers equal; level = wr_ptr - rd_ptr (modulo).
- cmd_valid = not empty; cmd_adr/cmd_d = head entry (first-word-fall-through); stable while cmd_valid=1 and cmd_ready=0.
- wr_count +1 per accepted push; holds at 32'hFFFFFFFF.
- ovf: set on drop; cleared by clr_ovf; set wins if drop and clr_ovf in same cycle.
- No address or data transformation; order strictly preserved.

## Timing
- Reset (rst_n=0, asynchronous): pointers 0, cmd_valid=0, cmd_adr=0, cmd_d=0, full=0, empty=1, level=0, ovf=0, wr_count=0. Storage contents need no reset.
- Latency: strobe accepted at edge N -> cmd_valid=1 with that entry after edge N (visible cycle N+1) if FIFO was empty.
- Pop at edge N -> next entry on cmd_adr/cmd_d after edge N; cmd_valid drops after N if it was the last entry.
- Throughput: one push and one pop per cycle sustained.
- full/empty/level/ovf/wr_count all registered or derived from registered pointers; no combinational path from w or cmd_ready to full/empty.
- Reset mid-operation: all queued commands discarded; controller sees cmd_valid fall asynchronously.

## Structure
- Shared package: AW/DW defaults, command struct {adr, data} width constant, DEPTH_LOG2 default.
- One sub-module: wr_cmd_ram — 2^DEPTH_LOG2 × (AW+DW) storage, one write port, asynchronous read at rd_ptr.
- Pointer, flag, counter and overflow logic in wr_cmd_buffer top.

## Test plan
- Reset then idle: empty=1, level=0, cmd_valid=0, wr_count=0, ovf=0 for 10 cycles.
- Single strobe adr=0x0000002, d=0x00000002, cmd_ready=0 -> cmd_valid=1 next cycle with same values, level=1; assert cmd_ready one cycle -> empty=1, wr_count=1.
- cmd_ready=0, 9 strobes adr=0,2,...,16 -> first 8 stored, full=1, level=8, ninth dropped, ovf=1, wr_count=8; drain -> adresses 0..14 in order.
- Full FIFO, w=1 and cmd_ready=1 same cycle -> level stays 8, ovf stays 0, wr_count+1, new entry last out.
- Pointer wrap: alternate strobe every 2nd cycle with cmd_ready=1 for 40 commands -> all 40 delivered in order, ovf=0, level never >1.
- Assert rst_n low with level=5 -> cmd_valid=0 immediately; after release empty=1, wr_count=0; clr_ovf with simultaneous drop leaves ovf=1.

Source files
------------

// File: rtl/wr_cmd_buffer_pkg.sv
// Shared definitions for the write-command buffer.
// Holds the default address/data widths, the default FIFO depth and the
// command layout ({adr, data}) that is stored in each FIFO entry.
package wr_cmd_buffer_pkg;

    localparam int AW_DEF         = 25;
    localparam int DW_DEF         = 32;
    localparam int DEPTH_LOG2_DEF = 3;

    // One stored command; address sits in the upper bits of the entry.
    typedef struct packed {
        logic [AW_DEF-1:0] adr;
        logic [DW_DEF-1:0] data;
    } wr_cmd_t;

    localparam int CMD_W_DEF = $bits(wr_cmd_t);

    function automatic int cmd_width(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/wr_cmd_ram.sv
// Command storage for wr_cmd_buffer.
// 2^DEPTH_LOG2 entries of WIDTH bits, one synchronous write port and one
// asynchronous read port, so the FIFO head is visible without a read cycle.
// Ports:
//   clk      system clock
//   we       write enable
//   wr_addr  write slot
//   wr_data  entry to store
//   rd_addr  read slot (FIFO head)
//   rd_data  entry at rd_addr, combinational
module wr_cmd_ram #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 57
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wr_cmd_buffer.sv
// Write-command buffer between the test pattern writer and the SDRAM
// controller write port. Every single-cycle strobe is queued in a small
// first-word-fall-through FIFO and offered to the controller with a
// valid/ready handshake. Occupancy, accepted-command count and a sticky
// overflow flag are reported.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   w, adr, d           write strobe with address/data from the pattern writer
//   cmd_valid/adr/d     head command towards the controller
//   cmd_ready           controller takes the head this cycle
//   full, empty, level  occupancy, derived from registered pointers only
//   ovf, clr_ovf        sticky drop flag and its synchronous clear
//   wr_count            saturating count of accepted strobes
module wr_cmd_buffer
    import wr_cmd_buffer_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w,
    input  logic [AW-1:0]         adr,
    input  logic [DW-1:0]         d,
    output logic                  cmd_valid,
    output logic [AW-1:0]         cmd_adr,
    output logic [DW-1:0]         cmd_d,
    input  logic                  cmd_ready,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf,
    input  logic                  clr_ovf,
    output logic [31:0]           wr_count
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam int CW = cmd_width(AW, DW);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    logic [CW-1:0] head;

    // The extra pointer bit separates full from empty when the slot bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign level = wr_ptr - rd_ptr;

    assign cmd_valid = !empty;
    assign pop       = cmd_valid && cmd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = w && (!full || pop);
    assign drop      = w && full && !pop;

    wr_cmd_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (CW)
    ) u_ram (
        .clk     (clk),
        .we      (push),
        .wr_addr (wr_ptr[PW-2:0]),
        .wr_data ({adr, d}),
        .rd_addr (rd_ptr[PW-2:0]),
        .rd_data (head)
    );

    // Storage is not reset, so the head is masked to zero while empty.
    assign {cmd_adr, cmd_d} = empty ? '0 : head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (push && (wr_count != 32'hFFFF_FFFF)) begin
            wr_count <= wr_count + 32'd1;
        end
    end

    // A drop in the same cycle as clr_ovf keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wr_cmd_buffer.sv
module tb_wr_cmd_buffer;

    localparam int AW    = 25;
    localparam int DW    = 32;
    localparam int DL2   = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          w = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [DW-1:0] d = '0;
    logic          cmd_valid;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_d;
    logic          cmd_ready = 1'b0;
    logic          full;
    logic          empty;
    logic [DL2:0]  level;
    logic          ovf;
    logic          clr_ovf = 1'b0;
    logic [31:0]   wr_count;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    wr_cmd_buffer #(.AW(AW), .DW(DW), .DEPTH_LOG2(DL2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w         (w),
        .adr       (adr),
        .d         (d),
        .cmd_valid (cmd_valid),
        .cmd_adr   (cmd_adr),
        .cmd_d     (cmd_d),
        .cmd_ready (cmd_ready),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf),
        .wr_count  (wr_count)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: a queue of {adr,d}, a count and a sticky flag.
    logic [AW+DW-1:0] mq[$];
    logic [31:0]      m_wr_count = '0;
    logic             m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_wr_count = '0;
            m_ovf = 1'b0;
        end else begin
            bit dropped;
            dropped = 1'b0;
            if (mq.size() != 0 && cmd_ready) begin
                void'(mq.pop_front());
            end
            if (w) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({adr, d});
                    if (m_wr_count != 32'hFFFF_FFFF) m_wr_count = m_wr_count + 1;
                end else begin
                    dropped = 1'b1;
                end
            end
            if (dropped) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checking && rst_n) begin
            logic [AW+DW-1:0] h;
            h = (mq.size() != 0) ? mq[0] : '0;
            chk("cmd_valid", 64'(cmd_valid), 64'(mq.size() != 0));
            chk("cmd_adr",   64'(cmd_adr),   64'(h[AW+DW-1:DW]));
            chk("cmd_d",     64'(cmd_d),     64'(h[DW-1:0]));
            chk("level",     64'(level),     64'(mq.size()));
            chk("full",      64'(full),      64'(mq.size() == DEPTH));
            chk("empty",     64'(empty),     64'(mq.size() == 0));
            chk("ovf",       64'(ovf),       64'(m_ovf));
            chk("wr_count",  64'(wr_count),  64'(m_wr_count));
        end
    end

    // Drive one cycle of inputs, return at the following negedge.
    task automatic step(input logic iw, input logic [AW-1:0] ia, input logic [DW-1:0] id,
                        input logic rdy, input logic clr);
        w = iw; adr = ia; d = id; cmd_ready = rdy; clr_ovf = clr;
        @(negedge clk);
        w = 1'b0; cmd_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        do_reset();
        checking = 1'b1;

        // Reset then idle.
        for (int i = 0; i < 10; i++) step(0, '0, '0, 0, 0);
        chk("idle_empty", 64'(empty), 64'd1);
        chk("idle_wr_count", 64'(wr_count), 64'd0);

        // Single strobe, then one-cycle ready.
        step(1, 25'h2, 32'h2, 0, 0);
        chk("single_valid", 64'(cmd_valid), 64'd1);
        chk("single_adr", 64'(cmd_adr), 64'h2);
        chk("single_d", 64'(cmd_d), 64'h2);
        chk("single_level", 64'(level), 64'd1);
        step(0, '0, '0, 1, 0);
        chk("single_empty", 64'(empty), 64'd1);
        chk("single_wr_count", 64'(wr_count), 64'd1);

        // Overflow: nine strobes without ready.
        do_reset();
        for (int i = 0; i < 9; i++) step(1, AW'(2 * i), DW'(32'hA000 + i), 0, 0);
        chk("ovf_full", 64'(full), 64'd1);
        chk("ovf_level", 64'(level), 64'd8);
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_wr_count", 64'(wr_count), 64'd8);
        step(0, '0, '0, 0, 1);
        chk("ovf_cleared", 64'(ovf), 64'd0);

        // Push and pop on a full FIFO.
        chk("pp_head", 64'(cmd_adr), 64'd0);
        step(1, 25'h100, 32'hBEEF, 1, 0);
        chk("pp_level", 64'(level), 64'd8);
        chk("pp_ovf", 64'(ovf), 64'd0);
        chk("pp_wr_count", 64'(wr_count), 64'd9);
        for (int i = 1; i < 8; i++) begin
            chk("drain_adr", 64'(cmd_adr), 64'(2 * i));
            step(0, '0, '0, 1, 0);
        end
        chk("drain_last_adr", 64'(cmd_adr), 64'h100);
        chk("drain_last_d", 64'(cmd_d), 64'hBEEF);
        step(0, '0, '0, 1, 0);
        chk("drain_empty", 64'(empty), 64'd1);

        // Pointer wrap: 40 commands, one strobe every second cycle.
        base = int'(wr_count);
        for (int i = 0; i < 40; i++) begin
            step(1, AW'($urandom), $urandom, 1, 0);
            chk("wrap_level_max", 64'(level <= 1), 64'd1);
            step(0, '0, '0, 1, 0);
            chk("wrap_level_max", 64'(level <= 1), 64'd1);
        end
        chk("wrap_count", 64'(wr_count), 64'(base + 40));
        chk("wrap_ovf", 64'(ovf), 64'd0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 60), AW'($urandom), $urandom,
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
        end

        // Asynchronous reset with five queued commands.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, AW'(i + 7), DW'(i), 0, 0);
        chk("pre_rst_level", 64'(level), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid_async", 64'(cmd_valid), 64'd0);
        chk("rst_level_async", 64'(level), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, '0, '0, 0, 0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_wr_count", 64'(wr_count), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        // Drop and clear in the same cycle: set wins.
        for (int i = 0; i < 8; i++) step(1, AW'(i), DW'(i), 0, 0);
        chk("clr_pre_ovf", 64'(ovf), 64'd0);
        step(1, 25'h55, 32'h55, 0, 1);
        chk("clr_vs_drop", 64'(ovf), 64'd1);
        chk("clr_wr_count", 64'(wr_count), 64'd8);

        step(0, '0, '0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
